// File: rtl/operand_fetch.sv
// Decode-stage operand latch: forwards EX/MEM/WB results onto RS/RT, stalls on load-use, feeds ID/EX.
// Optional feature: define OPFETCH_BYPASS_EN to enable forwarding; otherwise every pending write stalls.
module operand_fetch #(
    parameter int unsigned W    = 32,
    parameter int unsigned CNTW = 16
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            IDvalid,
    input  logic [4:0]      IDRSaddr,
    input  logic [4:0]      IDRTaddr,
    input  logic [4:0]      IDRDaddr,
    input  logic [W-1:0]    RS,
    input  logic [W-1:0]    RT,
    input  logic            EXwen,
    input  logic            EXload,
    input  logic [4:0]      EXaddr,
    input  logic [W-1:0]    EXdata,
    input  logic            MEMwen,
    input  logic [4:0]      MEMaddr,
    input  logic [W-1:0]    MEMdata,
    input  logic            WBwen,
    input  logic [4:0]      WBaddr,
    input  logic [W-1:0]    WBdata,
    input  logic            EXhold,
    input  logic            Flush,
    output logic            IDstall,
    output logic            OPvalid,
    output logic [W-1:0]    OPA,
    output logic [W-1:0]    OPB,
    output logic [4:0]      OPRDaddr,
    output logic [CNTW-1:0] StallCnt
);
    localparam logic [CNTW-1:0] CNT_MAX = '1;

    logic [W-1:0] opa_sel;
    logic [W-1:0] opb_sel;
    logic         lu;

`ifdef OPFETCH_BYPASS_EN
    // Youngest producer wins; an EX load has no data yet and is left to the stall.
    always_comb begin
        opa_sel = RS;
        if (IDRSaddr == 5'd0)                              opa_sel = {W{1'b0}};
        else if (EXwen && !EXload && EXaddr == IDRSaddr)   opa_sel = EXdata;
        else if (MEMwen && MEMaddr == IDRSaddr)            opa_sel = MEMdata;
        else if (WBwen && WBaddr == IDRSaddr)              opa_sel = WBdata;
    end

    always_comb begin
        opb_sel = RT;
        if (IDRTaddr == 5'd0)                              opb_sel = {W{1'b0}};
        else if (EXwen && !EXload && EXaddr == IDRTaddr)   opb_sel = EXdata;
        else if (MEMwen && MEMaddr == IDRTaddr)            opb_sel = MEMdata;
        else if (WBwen && WBaddr == IDRTaddr)              opb_sel = WBdata;
    end

    always_comb begin
        lu = IDvalid && EXwen && EXload && (EXaddr != 5'd0) &&
             ((EXaddr == IDRSaddr) || (EXaddr == IDRTaddr));
    end
`else
    logic rs_busy;
    logic rt_busy;
    logic unused_fwd;

    // Without bypass any in-flight write to a source must drain to the register file first.
    always_comb begin
        opa_sel = (IDRSaddr == 5'd0) ? {W{1'b0}} : RS;
        opb_sel = (IDRTaddr == 5'd0) ? {W{1'b0}} : RT;
        rs_busy = (IDRSaddr != 5'd0) &&
                  ((EXwen && EXaddr == IDRSaddr) || (MEMwen && MEMaddr == IDRSaddr) ||
                   (WBwen && WBaddr == IDRSaddr));
        rt_busy = (IDRTaddr != 5'd0) &&
                  ((EXwen && EXaddr == IDRTaddr) || (MEMwen && MEMaddr == IDRTaddr) ||
                   (WBwen && WBaddr == IDRTaddr));
        lu      = IDvalid && (rs_busy || rt_busy);
    end

    assign unused_fwd = ^{EXload, EXdata, MEMdata, WBdata};
`endif

    assign IDstall = EXhold | lu;

    // ID/EX register: flush beats hold, hold beats bubble.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            OPvalid  <= 1'b0;
            OPA      <= {W{1'b0}};
            OPB      <= {W{1'b0}};
            OPRDaddr <= 5'd0;
        end else if (Flush) begin
            OPvalid <= 1'b0;
        end else if (!EXhold) begin
            if (lu) begin
                OPvalid <= 1'b0;
            end else begin
                OPvalid  <= IDvalid;
                OPA      <= opa_sel;
                OPB      <= opb_sel;
                OPRDaddr <= IDRDaddr;
            end
        end
    end

    // Saturating count of bubbles actually inserted by hazards.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            StallCnt <= {CNTW{1'b0}};
        end else if (lu && !EXhold && !Flush && (StallCnt != CNT_MAX)) begin
            StallCnt <= StallCnt + CNTW'(1);
        end
    end

endmodule
